// File: rtl/cpu_pkg.sv
// Shared pipeline types plus the load-extract and store-lane helpers
// used by the memory-access stage.
package cpu_pkg;

  localparam int MEM_ADDR_WIDTH = 10;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic [1:0] memSize;
    logic       ldUnsigned;
  } Ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    Ctrl_t       ctrl;
    logic [31:0] aluresult;
    logic [31:0] op2;
    logic [31:0] ld_data;
    logic        excp;
  } Ma_Wb_t;

  typedef struct packed {
    logic       valid;
    Ma_Wb_t     pkt;
    logic [1:0] offset;
  } Lsu_Slot_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } St_Lane_t;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return ((size == SZ_H) & off[0]) |
           ((size == SZ_W) & (off != 2'd0));
  endfunction

  function automatic logic [31:0] load_extract(
    input logic [31:0] rdata,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {off, 3'b000};
    unique case (1'b1)
      (size == SZ_B):
        res = uns ? {24'd0, sh[7:0]}
                  : {{24{sh[7]}}, sh[7:0]};
      (size == SZ_H):
        res = uns ? {16'd0, sh[15:0]}
                  : {{16{sh[15]}}, sh[15:0]};
      default:
        res = sh;
    endcase
    return res;
  endfunction

  function automatic St_Lane_t store_lanes(
    input logic [31:0] op2,
    input logic [1:0]  off,
    input logic [1:0]  size
  );
    St_Lane_t s;
    unique case (1'b1)
      (size == SZ_B): begin
        s.data = {4{op2[7:0]}};
        s.strb = 4'b0001 << off;
      end
      (size == SZ_H): begin
        s.data = {2{op2[15:0]}};
        s.strb = 4'b0011 << off;
      end
      default: begin
        s.data = op2;
        s.strb = 4'b1111;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ma_lsu_fifo.sv
// Generic synchronous FIFO with flush and occupancy count;
// the head entry is presented straight from storage.
module ma_lsu_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Flush_i,
  input  logic                       Push_i,
  input  T                           Push_Data_i,
  input  logic                       Pop_i,
  output T                           Head_o,
  output logic                       Empty_o,
  output logic [$clog2(DEPTH+1)-1:0] Count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [CW-1:0]  cnt;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (Flush_i) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (Push_i) begin
        mem[wptr] <= Push_Data_i;
        wptr      <= inc(wptr);
      end
      if (Pop_i) rptr <= inc(rptr);
      case ({Push_i, Pop_i})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign Head_o  = mem[rptr];
  assign Empty_o = (cnt == '0);
  assign Count_o = cnt;

endmodule

// File: rtl/ma_lsu.sv
// Memory-access stage: pipelined DMEM loads/stores behind a fixed
// delay line and an in-order response FIFO towards WB.
module ma_lsu
  import cpu_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Flush_i,
  input  Ma_Wb_t                    Ex_Payld_i,
  input  logic                      Ex_Valid_i,
  output logic                      Ex_Ready_o,
  output logic [MEM_ADDR_WIDTH-1:0] Dmem_Waddr,
  output logic [31:0]               Dmem_Wdata,
  output logic [3:0]                Dmem_Wstrb,
  output logic                      Dmem_Wen,
  output logic [MEM_ADDR_WIDTH-1:0] Dmem_Raddr,
  output logic                      Dmem_Ren,
  input  logic [31:0]               Dmem_Rdata,
  output Ma_Wb_t                    Ma_Payld_o,
  output logic                      Ma_Valid_o,
  input  logic                      Ma_Ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  Lsu_Slot_t      dl [RD_LAT];
  Lsu_Slot_t      last;
  Ma_Wb_t         in_pkt;
  Ma_Wb_t         out_pkt;
  St_Lane_t       lane;
  logic [1:0]     off;
  logic           mis;
  logic           mem_op;
  logic           accept;
  logic           push;
  logic           pop;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_cnt;
  logic [7:0]     occ;

  assign off = Ex_Payld_i.aluresult[1:0];

  // Credits: every in-flight or queued packet owns a FIFO slot.
  always_comb begin
    occ = 8'(fifo_cnt);
    for (int i = 0; i < RD_LAT; i++) occ = occ + 8'(dl[i].valid);
  end

  assign Ex_Ready_o = Rst_n & !Flush_i & (occ < 8'(FIFO_DEPTH));
  assign accept     = Ex_Valid_i & Ex_Ready_o;

  always_comb begin
    mis            = misaligned(Ex_Payld_i.ctrl.memSize, off);
    mem_op         = Ex_Payld_i.ctrl.memRead | Ex_Payld_i.ctrl.memWrite;
    in_pkt         = Ex_Payld_i;
    in_pkt.ld_data = '0;
    in_pkt.excp    = Ex_Payld_i.excp | (mem_op & mis);
    lane           = store_lanes(Ex_Payld_i.op2, off,
                                 Ex_Payld_i.ctrl.memSize);
    Dmem_Waddr     = '0;
    Dmem_Wdata     = '0;
    Dmem_Wstrb     = '0;
    Dmem_Wen       = 1'b0;
    Dmem_Raddr     = '0;
    Dmem_Ren       = 1'b0;
    if (accept & !mis) begin
      if (Ex_Payld_i.ctrl.memWrite) begin
        Dmem_Wen   = 1'b1;
        Dmem_Waddr = Ex_Payld_i.aluresult[MEM_ADDR_WIDTH+1:2];
        Dmem_Wdata = lane.data;
        Dmem_Wstrb = lane.strb;
      end
      if (Ex_Payld_i.ctrl.memRead) begin
        Dmem_Ren   = 1'b1;
        Dmem_Raddr = Ex_Payld_i.aluresult[MEM_ADDR_WIDTH+1:2];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < RD_LAT; i++) dl[i] <= '0;
    end else if (Flush_i) begin
      for (int i = 0; i < RD_LAT; i++) dl[i].valid <= 1'b0;
    end else begin
      dl[0] <= '{valid: accept, pkt: in_pkt, offset: off};
      for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
    end
  end

  // Read data lines up with the last delay slot.
  always_comb begin
    last    = dl[RD_LAT-1];
    push    = last.valid;
    out_pkt = last.pkt;
    if (last.pkt.ctrl.memRead & !last.pkt.excp)
      out_pkt.ld_data = load_extract(Dmem_Rdata, last.offset,
                                     last.pkt.ctrl.memSize,
                                     last.pkt.ctrl.ldUnsigned);
  end

  assign Ma_Valid_o = !fifo_empty;
  assign pop        = Ma_Valid_o & Ma_Ready_i;

  ma_lsu_fifo #(
    .T     (Ma_Wb_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Flush_i     (Flush_i),
    .Push_i      (push),
    .Push_Data_i (out_pkt),
    .Pop_i       (pop),
    .Head_o      (Ma_Payld_o),
    .Empty_o     (fifo_empty),
    .Count_o     (fifo_cnt)
  );

endmodule

// File: tb/tb_ma_lsu.sv
// Directed bench for ma_lsu with RD_LAT=2, FIFO_DEPTH=4 and a
// small byte-lane DMEM model with two-cycle read latency.
module tb_ma_lsu;
  import cpu_pkg::*;

  logic                      Clk = 1'b0;
  logic                      Rst_n = 1'b0;
  logic                      Flush_i = 1'b0;
  Ma_Wb_t                    Ex_Payld_i = '0;
  logic                      Ex_Valid_i = 1'b0;
  logic                      Ex_Ready_o;
  logic [MEM_ADDR_WIDTH-1:0] Dmem_Waddr;
  logic [31:0]               Dmem_Wdata;
  logic [3:0]                Dmem_Wstrb;
  logic                      Dmem_Wen;
  logic [MEM_ADDR_WIDTH-1:0] Dmem_Raddr;
  logic                      Dmem_Ren;
  logic [31:0]               Dmem_Rdata;
  Ma_Wb_t                    Ma_Payld_o;
  logic                      Ma_Valid_o;
  logic                      Ma_Ready_i = 1'b1;

  int total = 0;
  int passed = 0;
  int n_acc;

  logic [31:0] mem [16];
  logic [31:0] p1, p2;

  always #5 Clk = ~Clk;

  ma_lsu #(.RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Flush_i    (Flush_i),
    .Ex_Payld_i (Ex_Payld_i),
    .Ex_Valid_i (Ex_Valid_i),
    .Ex_Ready_o (Ex_Ready_o),
    .Dmem_Waddr (Dmem_Waddr),
    .Dmem_Wdata (Dmem_Wdata),
    .Dmem_Wstrb (Dmem_Wstrb),
    .Dmem_Wen   (Dmem_Wen),
    .Dmem_Raddr (Dmem_Raddr),
    .Dmem_Ren   (Dmem_Ren),
    .Dmem_Rdata (Dmem_Rdata),
    .Ma_Payld_o (Ma_Payld_o),
    .Ma_Valid_o (Ma_Valid_o),
    .Ma_Ready_i (Ma_Ready_i)
  );

  always @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[4] <= 32'h1122_3344;
      mem[5] <= 32'h8000_FF80;
      p1     <= '0;
      p2     <= '0;
    end else begin
      p1 <= Dmem_Ren ? mem[Dmem_Raddr[3:0]] : 32'hDEAD_BEEF;
      p2 <= p1;
      if (Dmem_Wen)
        for (int b = 0; b < 4; b++)
          if (Dmem_Wstrb[b])
            mem[Dmem_Waddr[3:0]][b*8 +: 8] <= Dmem_Wdata[b*8 +: 8];
    end
  end

  assign Dmem_Rdata = p2;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input Ma_Wb_t p);
    Ex_Payld_i = p;
    Ex_Valid_i = 1'b1;
    #1;
  endtask

  task automatic idle();
    Ex_Payld_i = '0;
    Ex_Valid_i = 1'b0;
  endtask

  function automatic Ma_Wb_t mk(input logic [31:0] pc,
                                input logic ld, input logic st,
                                input logic [1:0] sz, input logic uns,
                                input logic [31:0] a,
                                input logic [31:0] d);
    Ma_Wb_t p;
    p = '0;
    p.pc              = pc;
    p.rd              = 5'd1;
    p.ctrl.regWrite   = !st;
    p.ctrl.memRead    = ld;
    p.ctrl.memWrite   = st;
    p.ctrl.memSize    = sz;
    p.ctrl.ldUnsigned = uns;
    p.aluresult       = a;
    p.op2             = d;
    return p;
  endfunction

  initial begin
    #12;
    chk("rst_valid", 32'(Ma_Valid_o), 0);
    chk("rst_payld", 32'(|Ma_Payld_o), 0);
    chk("rst_ready", 32'(Ex_Ready_o), 0);
    chk("rst_dmem", 32'(Dmem_Ren | Dmem_Wen), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();
    chk("rel_ready", 32'(Ex_Ready_o), 1);

    // back-to-back loads
    drive(mk(32'h1, 1, 0, SZ_W, 0, 32'h10, 0));
    chk("lw_ren", 32'(Dmem_Ren), 1);
    chk("lw_raddr", 32'(Dmem_Raddr), 32'h4);
    chk("lw_ready", 32'(Ex_Ready_o), 1);
    tick();
    drive(mk(32'h2, 1, 0, SZ_B, 0, 32'h13, 0));
    chk("lb_raddr", 32'(Dmem_Raddr), 32'h4);
    chk("lb_ready", 32'(Ex_Ready_o), 1);
    tick();
    drive(mk(32'h3, 1, 0, SZ_H, 1, 32'h16, 0));
    chk("lhu_raddr", 32'(Dmem_Raddr), 32'h5);
    chk("lhu_ready", 32'(Ex_Ready_o), 1);
    chk("lat_early", 32'(Ma_Valid_o), 0);
    tick();
    idle();
    chk("lw_valid", 32'(Ma_Valid_o), 1);
    chk("lw_pc", Ma_Payld_o.pc, 32'h1);
    chk("lw_data", Ma_Payld_o.ld_data, 32'h1122_3344);
    tick();
    chk("lb_valid", 32'(Ma_Valid_o), 1);
    chk("lb_data", Ma_Payld_o.ld_data, 32'h0000_0011);
    tick();
    chk("lhu_valid", 32'(Ma_Valid_o), 1);
    chk("lhu_data", Ma_Payld_o.ld_data, 32'h0000_8000);
    tick();
    chk("b2b_drain", 32'(Ma_Valid_o), 0);

    // store lanes, then read the word back
    drive(mk(32'h10, 0, 1, SZ_B, 0, 32'h21, 32'hAB));
    chk("sb_wen", 32'(Dmem_Wen), 1);
    chk("sb_wstrb", 32'(Dmem_Wstrb), 32'h2);
    chk("sb_wdata", Dmem_Wdata, 32'hABAB_ABAB);
    chk("sb_waddr", 32'(Dmem_Waddr), 32'h8);
    chk("sb_ren", 32'(Dmem_Ren), 0);
    tick();
    drive(mk(32'h11, 0, 1, SZ_H, 0, 32'h22, 32'h1234));
    chk("sh_wstrb", 32'(Dmem_Wstrb), 32'hC);
    chk("sh_wdata", Dmem_Wdata, 32'h1234_1234);
    chk("sh_waddr", 32'(Dmem_Waddr), 32'h8);
    tick();
    drive(mk(32'h12, 1, 0, SZ_W, 0, 32'h20, 0));
    tick();
    idle();
    chk("sb_pc", Ma_Payld_o.pc, 32'h10);
    chk("sb_ld0", Ma_Payld_o.ld_data, 0);
    tick();
    chk("sh_pc", Ma_Payld_o.pc, 32'h11);
    tick();
    chk("rb_pc", Ma_Payld_o.pc, 32'h12);
    chk("rb_data", Ma_Payld_o.ld_data, 32'h1234_AB00);
    tick();

    // misaligned load and store
    drive(mk(32'h20, 1, 0, SZ_W, 0, 32'h31, 0));
    chk("mis_ren", 32'(Dmem_Ren), 0);
    chk("mis_ready", 32'(Ex_Ready_o), 1);
    tick();
    drive(mk(32'h21, 0, 1, SZ_H, 0, 32'h33, 32'h55));
    chk("mis_wen", 32'(Dmem_Wen), 0);
    tick();
    idle();
    tick();
    chk("mis_valid", 32'(Ma_Valid_o), 1);
    chk("mis_pc", Ma_Payld_o.pc, 32'h20);
    chk("mis_excp", 32'(Ma_Payld_o.excp), 1);
    chk("mis_ld0", Ma_Payld_o.ld_data, 0);
    tick();
    chk("miss_excp", 32'(Ma_Payld_o.excp), 1);
    tick();

    // backpressure
    Ma_Ready_i = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(mk(32'h100 + n_acc, 0, 0, SZ_W, 0, 32'h0, 0));
      if (Ex_Ready_o) n_acc++;
      if (Ma_Valid_o) chk("bp_head", Ma_Payld_o.pc, 32'h100);
      tick();
    end
    idle();
    chk("bp_count", n_acc, 4);
    chk("bp_ready", 32'(Ex_Ready_o), 0);
    Ma_Ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 32'(Ma_Valid_o), 1);
      chk("bp_order", Ma_Payld_o.pc, 32'h100 + i);
      tick();
    end
    chk("bp_empty", 32'(Ma_Valid_o), 0);

    // flush with two loads in flight and one queued
    Ma_Ready_i = 1'b0;
    drive(mk(32'h200, 1, 0, SZ_W, 0, 32'h10, 0));
    tick();
    idle();
    tick();
    drive(mk(32'h201, 1, 0, SZ_W, 0, 32'h14, 0));
    tick();
    drive(mk(32'h202, 1, 0, SZ_W, 0, 32'h10, 0));
    tick();
    drive(mk(32'h2FF, 1, 0, SZ_W, 0, 32'h10, 0));
    Flush_i = 1'b1;
    #1;
    chk("fl_ready", 32'(Ex_Ready_o), 0);
    chk("fl_ren", 32'(Dmem_Ren), 0);
    chk("fl_queued", 32'(Ma_Valid_o), 1);
    tick();
    Flush_i = 1'b0;
    Ma_Ready_i = 1'b1;
    chk("fl_cleared", 32'(Ma_Valid_o), 0);
    drive(mk(32'h300, 0, 0, SZ_W, 0, 32'h0, 0));
    chk("fl_ready2", 32'(Ex_Ready_o), 1);
    tick();
    idle();
    chk("fl_gap1", 32'(Ma_Valid_o), 0);
    tick();
    chk("fl_gap2", 32'(Ma_Valid_o), 0);
    tick();
    chk("fl_alu_v", 32'(Ma_Valid_o), 1);
    chk("fl_alu_pc", Ma_Payld_o.pc, 32'h300);
    tick();
    chk("fl_alone", 32'(Ma_Valid_o), 0);

    // asynchronous reset with a load in flight
    drive(mk(32'h400, 1, 0, SZ_W, 0, 32'h10, 0));
    tick();
    drive(mk(32'h401, 1, 0, SZ_W, 0, 32'h14, 0));
    #1;
    Rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(Ma_Valid_o), 0);
    chk("ar_ready", 32'(Ex_Ready_o), 0);
    chk("ar_ren", 32'(Dmem_Ren), 0);
    chk("ar_payld", 32'(|Ma_Payld_o), 0);
    idle();
    tick();
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ar_stale", 32'(Ma_Valid_o), 0);
    end
    chk("ar_rel_ready", 32'(Ex_Ready_o), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
